// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a byte FIFO with one-cycle read latency
// and packs PACK lanes little-endian into a valid/ready word.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep
);

  localparam int CW = $clog2(PACK + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CW-1:0]              lane_cnt;
  logic [CW-1:0]              cnt_nxt;
  logic [CW:0]                lanes_busy;
  logic [PACK:0]              one_sh;
  logic [PACK-1:0]            part_mask;
  logic                       pend;
  logic                       flush_req;
  logic                       full_go;
  logic                       flush_go;
  logic                       flush_drop;
  logic [PACK-1:0]            keep_q;
  logic [DATA_WIDTH*PACK-1:0] data_q;

  // lane count after this edge's capture and the resulting exits
  always_comb begin
    cnt_nxt    = lane_cnt + CW'(pend);
    lanes_busy = (CW+1)'(lane_cnt) + (CW+1)'(pend);
    one_sh     = (PACK+1)'(1) << cnt_nxt;
    part_mask  = PACK'(one_sh - (PACK+1)'(1));
    full_go    = (state == FILL) && (cnt_nxt == CW'(PACK));
    flush_go   = (state == FILL) && flush_req && !pend
                 && (cnt_nxt != '0);
    flush_drop = (state == FILL) && flush_req && !pend
                 && (cnt_nxt == '0);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (full_go || flush_go) state_nxt = HOLD;
      HOLD: if (out_ready)           state_nxt = FILL;
      default:                       state_nxt = FILL;
    endcase
  end

  // FSM outputs: read request only while filling with room left
  always_comb begin
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      FILL: fifo_rd_en = !rst && !fifo_empty && !flush_req
                         && (lanes_busy < (CW+1)'(PACK));
      HOLD: out_valid  = 1'b1;
      default: ;
    endcase
  end

  // lane capture, flush latch and word/mask registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt  <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      keep_q    <= '0;
      data_q    <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (state == FILL) begin
        if (pend) begin
          data_q[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
          lane_cnt <= cnt_nxt;
        end
        flush_req <= flush || (flush_req && !flush_drop);
        if (full_go)       keep_q <= '1;
        else if (flush_go) keep_q <= part_mask;
      end else if (out_ready) begin
        lane_cnt  <= '0;
        keep_q    <= '0;
        data_q    <= '0;
        flush_req <= 1'b0;
      end
    end
  end

  assign out_data = data_q;
  assign out_keep = keep_q;

endmodule
